oled_frame_arbiter: RTL and testbench

Shares the single 96x64 OLED between up to eight pixel-generator tasks, such as the per-task pattern/digit generators. It tracks the current pixel coordinate (x, y) for all tasks and grants the display to one requester at a time, round-robin. Ownership changes only on frame boundaries, so no frame ever tears. The registered oled_data output feeds the OLED driver directly.

---
 rtl/oled_frame_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_oled_frame_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_frame_arbiter.sv
// Round-robin, frame-aligned arbiter sharing one 96x64 OLED among pixel sources.
// Define OLED_BLANK_FRAME_EN to insert one blank frame before each new owner.
module oled_frame_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter int          MIN_FRAMES = 2,
  parameter int          WIDTH      = 96,
  parameter int          HEIGHT     = 64,
  parameter logic [15:0] IDLE_COLOR = 16'h0000
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   frame_begin,
  input  logic                   sample_pixel,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [NUM_SRC*16-1:0]  src_data,
  output logic [6:0]             x,
  output logic [6:0]             y,
  output logic [NUM_SRC-1:0]     grant,
  output logic [3:0]             grant_id,
  output logic [15:0]            oled_data
);

  localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
  localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
  localparam logic [3:0] HOLD_MIN = 4'(MIN_FRAMES);
  localparam logic [3:0] SRC_LAST = 4'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_BLANK
  } state_t;

  state_t state, state_n;

  logic [3:0] owner, owner_n;
  logic [3:0] held, held_n;
  logic [3:0] rr_ptr, ptr_n;

  logic [NUM_SRC-1:0] own_oh;
  logic               own_req;
  logic [15:0]        own_pix;
  logic [4:0]         pick_any;
  logic [4:0]         pick_oth;
  logic               go;
  logic [3:0]         go_idx;

`ifdef OLED_BLANK_FRAME_EN
  logic [3:0]         pend, pend_n;
  logic [NUM_SRC-1:0] pend_oh;
  logic               pend_req;
  logic               direct;
`endif

  // {found, index}: first request at or after ptr, wrapping, optionally skipping one index
  function automatic logic [4:0] rr_pick(
    input logic [NUM_SRC-1:0] r,
    input logic [3:0]         ptr,
    input logic               excl_en,
    input logic [3:0]         excl
  );
    logic [4:0] res;
    int         best;
    int         d;
    res  = '0;
    best = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i >= int'(ptr)) d = i - int'(ptr);
      else                d = i + NUM_SRC - int'(ptr);
      if (r[i] && !(excl_en && excl == 4'(i)) && d < best) begin
        best = d;
        res  = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] next_idx(input logic [3:0] i);
    return (i == SRC_LAST) ? 4'd0 : i + 4'd1;
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (frame_begin) begin
      x <= '0;
      y <= '0;
    end else if (sample_pixel) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? 7'd0 : y + 7'd1;
      end else begin
        x <= x + 7'd1;
      end
    end
  end

  always_comb begin
    own_oh  = '0;
    own_pix = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      own_oh[i] = (owner == 4'(i));
      if (owner == 4'(i)) own_pix = src_data[16*i +: 16];
    end
    own_req = |(req & own_oh);
  end

`ifdef OLED_BLANK_FRAME_EN
  always_comb begin
    pend_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_oh[i] = (pend == 4'(i));
    end
    pend_req = |(req & pend_oh);
  end
`endif

  assign pick_any = rr_pick(req, rr_ptr, 1'b0, 4'd0);
  assign pick_oth = rr_pick(req, rr_ptr, 1'b1, owner);

  always_comb begin
    state_n = state;
    owner_n = owner;
    held_n  = held;
    ptr_n   = rr_ptr;
    go      = 1'b0;
    go_idx  = '0;
`ifdef OLED_BLANK_FRAME_EN
    pend_n  = pend;
    direct  = 1'b0;
`endif
    if (frame_begin) begin
      case (state)
        S_IDLE: begin
          if (pick_any[4]) begin
            go     = 1'b1;
            go_idx = pick_any[3:0];
          end
        end
        S_OWN: begin
          if (!own_req) begin
            if (pick_oth[4]) begin
              go     = 1'b1;
              go_idx = pick_oth[3:0];
            end else begin
              state_n = S_IDLE;
            end
          end else if (held >= HOLD_MIN && pick_oth[4]) begin
            go     = 1'b1;
            go_idx = pick_oth[3:0];
          end else if (held != 4'hF) begin
            held_n = held + 4'd1;
          end
        end
        S_BLANK: begin
`ifdef OLED_BLANK_FRAME_EN
          direct = 1'b1;
          if (pend_req) begin
            go     = 1'b1;
            go_idx = pend;
          end else if (pick_any[4]) begin
            go     = 1'b1;
            go_idx = pick_any[3:0];
          end else begin
            state_n = S_IDLE;
          end
`else
          state_n = S_IDLE;
`endif
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (go) begin
`ifdef OLED_BLANK_FRAME_EN
      if (!direct) begin
        state_n = S_BLANK;
        pend_n  = go_idx;
      end else begin
        state_n = S_OWN;
        owner_n = go_idx;
        held_n  = 4'd1;
        ptr_n   = next_idx(go_idx);
      end
`else
      state_n = S_OWN;
      owner_n = go_idx;
      held_n  = 4'd1;
      ptr_n   = next_idx(go_idx);
`endif
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= '0;
      held      <= '0;
      rr_ptr    <= '0;
      oled_data <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      held      <= held_n;
      rr_ptr    <= ptr_n;
      oled_data <= (state == S_OWN) ? own_pix : IDLE_COLOR;
    end
  end

`ifdef OLED_BLANK_FRAME_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_n;
  end
`endif

  assign grant    = (state == S_OWN) ? own_oh : '0;
  assign grant_id = (state == S_OWN) ? owner : 4'hF;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Testbench for oled_frame_arbiter: randomized and directed stimulus checked
// against a frame-level reference model of ownership and pixel position.
module tb_oled_frame_arbiter;

  localparam int N    = 4;
  localparam int MINF = 2;
  localparam int W    = 96;
  localparam int H    = 64;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_begin = 1'b0;
  logic            sample_pixel = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*16-1:0] src_data;
  logic [6:0]      x;
  logic [6:0]      y;
  logic [N-1:0]    grant;
  logic [3:0]      grant_id;
  logic [15:0]     oled_data;

  bit          const_mode = 1'b0;
  logic [15:0] cval [N];

  int checks = 0;
  int fails  = 0;

  int          m_pix;
  int          m_own;
  int          m_held;
  int          m_ptr;
  int          m_pend;
  bit          m_blank;
  logic [15:0] m_data;

  oled_frame_arbiter dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .frame_begin  (frame_begin),
    .sample_pixel (sample_pixel),
    .req          (req),
    .src_data     (src_data),
    .x            (x),
    .y            (y),
    .grant        (grant),
    .grant_id     (grant_id),
    .oled_data    (oled_data)
  );

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_src
    assign src_data[16*g +: 16] =
      const_mode ? cval[g] : {3'(g), x, y[5:0]};
  end

  function automatic logic [15:0] pix(int i, int px, int py);
    if (const_mode) return cval[i];
    return {3'(i), 7'(px), 6'(py)};
  endfunction

  function automatic int rr(int excl);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pix = 0; m_own = -1; m_held = 0; m_ptr = 0;
    m_pend = 0; m_blank = 0; m_data = 16'h0000;
  endtask

  task automatic model_take(int w);
    m_own = w; m_held = 1; m_ptr = (w + 1) % N; m_blank = 0;
  endtask

  task automatic model_change(int w);
`ifdef OLED_BLANK_FRAME_EN
    m_blank = 1; m_pend = w; m_own = -1;
`else
    model_take(w);
`endif
  endtask

  task automatic model_edge(bit fb, bit sp);
    logic [15:0] nd;
    int w;
    nd = (m_own >= 0) ? pix(m_own, m_pix % W, m_pix / W) : 16'h0000;
    if (fb) begin
      if (m_blank) begin
        if (req[m_pend]) model_take(m_pend);
        else begin
          w = rr(-1);
          if (w >= 0) model_take(w);
          else m_blank = 0;
        end
      end else if (m_own < 0) begin
        w = rr(-1);
        if (w >= 0) model_change(w);
      end else if (!req[m_own]) begin
        w = rr(m_own);
        if (w >= 0) model_change(w);
        else m_own = -1;
      end else begin
        w = rr(m_own);
        if (m_held >= MINF && w >= 0) model_change(w);
        else if (m_held < 15) m_held++;
      end
    end
    if (fb) m_pix = 0;
    else if (sp) m_pix = (m_pix + 1) % (W * H);
    m_data = nd;
  endtask

  function automatic logic [37:0] expect_vec();
    logic [N-1:0] eg;
    logic [3:0]   eid;
    eg  = '0;
    eid = 4'hF;
    if (m_own >= 0) begin
      eg[m_own] = 1'b1;
      eid = 4'(m_own);
    end
    return {7'(m_pix % W), 7'(m_pix / W), eg, eid, m_data};
  endfunction

  task automatic step(bit fb, bit sp);
    frame_begin  = fb;
    sample_pixel = sp;
    @(posedge clock);
    model_edge(fb, sp);
    #1;
    frame_begin  = 1'b0;
    sample_pixel = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req = 4'b1111;
    step(1, 0);
    repeat (20) begin
      step(0, 1);
      checks++;
      if ({x, y, grant, grant_id, oled_data} !== expect_vec()) begin
        fails++;
        $display("FAIL pre_reset got %h want %h",
                 {x, y, grant, grant_id, oled_data}, expect_vec());
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x, y, grant, grant_id, oled_data} !== {7'd0, 7'd0, 4'd0, 4'hF, 16'h0}) begin
      fails++;
      $display("FAIL async_reset got %h want %h",
               {x, y, grant, grant_id, oled_data},
               {7'd0, 7'd0, 4'd0, 4'hF, 16'h0});
    end
    model_reset();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    step(1, 0);
`ifdef OLED_BLANK_FRAME_EN
    step(1, 0);
`endif
    checks++;
    if (grant_id !== 4'd0 || grant !== 4'b0001) begin
      fails++;
      $display("FAIL first_grant got %h/%b want 0/0001", grant_id, grant);
    end
  endtask

  task automatic test_coord_wrap();
    req = '0;
    step(1, 0);
    for (int i = 0; i < W * H - 1; i++) begin
      step(0, 1);
      checks++;
      if ({x, y, grant, grant_id, oled_data} !== expect_vec()) begin
        fails++;
        $display("FAIL coord_scan %0d got %h want %h", i,
                 {x, y, grant, grant_id, oled_data}, expect_vec());
      end
    end
    checks++;
    if (x !== 7'd95 || y !== 7'd63) begin
      fails++;
      $display("FAIL coord_last got %0d,%0d want 95,63", x, y);
    end
    step(0, 1);
    checks++;
    if (x !== 7'd0 || y !== 7'd0) begin
      fails++;
      $display("FAIL coord_wrap got %0d,%0d want 0,0", x, y);
    end
    repeat (10) step(0, 1);
    checks++;
    if (x !== 7'd10) begin
      fails++;
      $display("FAIL coord_ten got %0d want 10", x);
    end
    step(1, 1);
    checks++;
    if (x !== 7'd0 || y !== 7'd0) begin
      fails++;
      $display("FAIL fb_priority got %0d,%0d want 0,0", x, y);
    end
  endtask

  task automatic test_rr_rotation();
    int seq [6] = '{0, 0, 2, 2, 0, 0};
    do_reset();
    req = 4'b0101;
    for (int f = 0; f < 6; f++) begin
      step(1, 0);
`ifndef OLED_BLANK_FRAME_EN
      checks++;
      if (grant_id !== 4'(seq[f])) begin
        fails++;
        $display("FAIL rr_seq frame %0d got %h want %h", f, grant_id, 4'(seq[f]));
      end
`endif
      repeat ($urandom_range(1, 8)) begin
        step(0, 1'($urandom));
        checks++;
        if ({x, y, grant, grant_id, oled_data} !== expect_vec()) begin
          fails++;
          $display("FAIL rr_frame got %h want %h",
                   {x, y, grant, grant_id, oled_data}, expect_vec());
        end
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 4'b0010;
    step(1, 0);
`ifdef OLED_BLANK_FRAME_EN
    step(1, 0);
`endif
    repeat (3) step(0, 1);
    req = 4'b1000;
    repeat (5) begin
      step(0, 1);
      checks++;
      if (grant !== 4'b0010 ||
          {x, y, grant, grant_id, oled_data} !== expect_vec()) begin
        fails++;
        $display("FAIL drop_hold got %h want %h",
                 {x, y, grant, grant_id, oled_data}, expect_vec());
      end
    end
    step(1, 0);
`ifdef OLED_BLANK_FRAME_EN
    checks++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL drop_blank got %b want 0000", grant);
    end
    step(1, 0);
`endif
    checks++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("FAIL drop_switch got %b want 1000", grant);
    end
  endtask

  task automatic test_const_pixels();
    do_reset();
    const_mode = 1'b1;
    cval[0] = 16'h1234;
    cval[1] = 16'h07E0;
    cval[2] = 16'hABCD;
    cval[3] = 16'hF800;
    req = 4'b1000;
    step(1, 0);
`ifdef OLED_BLANK_FRAME_EN
    step(1, 0);
`endif
    checks++;
    if (grant_id !== 4'd3 || oled_data !== 16'h0000) begin
      fails++;
      $display("FAIL const_grant got %h/%h want 3/0000", grant_id, oled_data);
    end
    req = 4'b1010;
    step(0, 1);
    checks++;
    if (oled_data !== 16'hF800) begin
      fails++;
      $display("FAIL const_pix got %h want F800", oled_data);
    end
    req = 4'b0000;
    step(1, 0);
    checks++;
    if (grant_id !== 4'hF || oled_data !== 16'hF800) begin
      fails++;
      $display("FAIL const_idle got %h/%h want F/F800", grant_id, oled_data);
    end
    step(0, 0);
    checks++;
    if (oled_data !== 16'h0000) begin
      fails++;
      $display("FAIL const_idle_pix got %h want 0000", oled_data);
    end
    const_mode = 1'b0;
  endtask

  task automatic test_blank_switch();
    do_reset();
    req = 4'b0001;
    step(1, 0);
`ifdef OLED_BLANK_FRAME_EN
    step(1, 0);
`endif
    step(0, 1);
    req = 4'b0100;
    step(1, 0);
`ifdef OLED_BLANK_FRAME_EN
    checks++;
    if (grant !== 4'b0000 || grant_id !== 4'hF) begin
      fails++;
      $display("FAIL blank_grant got %b/%h want 0000/F", grant, grant_id);
    end
    step(0, 1);
    checks++;
    if (oled_data !== 16'h0000) begin
      fails++;
      $display("FAIL blank_pix got %h want 0000", oled_data);
    end
    step(1, 0);
`endif
    checks++;
    if (grant !== 4'b0100) begin
      fails++;
      $display("FAIL switch_grant got %b want 0100", grant);
    end
    step(0, 1);
    checks++;
    if ({x, y, grant, grant_id, oled_data} !== expect_vec()) begin
      fails++;
      $display("FAIL switch_pix got %h want %h",
               {x, y, grant, grant_id, oled_data}, expect_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 300; f++) begin
      req = N'($urandom);
      step(1, 1'($urandom));
      checks++;
      if ({x, y, grant, grant_id, oled_data} !== expect_vec()) begin
        fails++;
        $display("FAIL rand_fb %0d got %h want %h", f,
                 {x, y, grant, grant_id, oled_data}, expect_vec());
      end
      repeat ($urandom_range(0, 15)) begin
        if ($urandom_range(0, 7) == 0) req = N'($urandom);
        step(0, 1'($urandom));
        checks++;
        if ({x, y, grant, grant_id, oled_data} !== expect_vec()) begin
          fails++;
          $display("FAIL rand_cyc %0d got %h want %h", f,
                   {x, y, grant, grant_id, oled_data}, expect_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_coord_wrap();
    test_rr_rotation();
    test_owner_drop();
    test_const_pixels();
    test_blank_switch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
